// File: rtl/rr_mux4to1_pkg.sv
// Shared constants, state and select encodings for the 4-to-1 round-robin merge.
package rr_mux4to1_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FULL   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Source tag encoding, shared with the 1-to-4 demux select.
    typedef enum logic [SEL_W-1:0] {
        SEL_CH0 = 2'd0,
        SEL_CH1 = 2'd1,
        SEL_CH2 = 2'd2,
        SEL_CH3 = 2'd3
    } sel_t;

    function automatic logic [NUM_CH-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_mux4to1_arb.sv
// Combinational round-robin picker: scans req from ptr upward (mod 4), first set bit wins.
module rr_arb4
    import rr_mux4to1_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux4to1.sv
// Four-channel valid/ready merge with round-robin arbitration and a single output register.
// Optional packet locking (in_last/out_last) is enabled with `define RR_MUX_PKT_LOCK_EN.
module rr_mux4to1
    import rr_mux4to1_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               load;
    logic               locked;
    logic               xfer;
    logic               xfer_last;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  gnt;
    logic [SEL_W-1:0]   gnt_idx;

`ifdef RR_MUX_PKT_LOCK_EN
    logic               out_last_q, out_last_d;

    // While locked only the channel that opened the packet may request.
    assign locked    = (state_q == ST_LOCKED);
    assign xfer_last = in_last[gnt_idx];
    assign out_last  = out_last_q;
`else
    assign locked    = 1'b0;
    assign xfer_last = 1'b1;
`endif

    assign load = !out_valid_q || out_ready;
    assign req  = locked ? (in_valid & sel2onehot(out_sel_q)) : in_valid;

    rr_arb4 u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Ready is withheld during reset so no producer sees a phantom handshake.
    assign in_ready = gnt & {NUM_CH{load & rst_n}};
    assign xfer     = |in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_PKT_LOCK_EN
        out_last_d  = out_last_q;
`endif
        if (load) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[32'(gnt_idx)*WIDTH +: WIDTH];
                out_sel_d   = gnt_idx;
`ifdef RR_MUX_PKT_LOCK_EN
                out_last_d  = xfer_last;
`endif
                if (xfer_last) begin
                    ptr_d   = gnt_idx + 2'd1;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_LOCKED;
                end
            end else begin
                out_valid_d = 1'b0;
                if (!locked) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_CH0;
            ptr_q       <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4to1.sv
// Self-checking bench for rr_mux4to1: directed scenarios plus randomized traffic against a reference model.
module tb_rr_mux4to1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [3:0]  in_last = 4'hF;
    logic        out_last;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rr_mux4to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // Leaves the bench aligned one time unit after a rising edge, DUT freshly reset.
    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        in_data   = 32'h43322110;
        in_valid  = 4'hF;
        rst_n     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
            checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else passed++;
            checks++; if (out_sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", out_sel); else passed++;
            checks++; if (in_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", in_ready); else passed++;
        end
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_valid();
        logic [7:0] exp_d;
        in_data   = 32'h43322110;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) $display("FAIL all_first_ready: got %b want 0001", in_ready); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            exp_d = 8'(16 + 17 * (i % 4));
            checks++; if (out_valid !== 1'b1) $display("FAIL all_valid beat %0d: got %b want 1", i, out_valid); else passed++;
            checks++; if (out_sel !== 2'(i % 4)) $display("FAIL all_sel beat %0d: got %0d want %0d", i, out_sel, i % 4); else passed++;
            checks++; if (out_data !== exp_d) $display("FAIL all_data beat %0d: got %h want %h", i, out_data, exp_d); else passed++;
            checks++; if (in_ready !== 4'(1 << ((i + 1) % 4))) $display("FAIL all_ready beat %0d: got %b want %b", i, in_ready, 4'(1 << ((i + 1) % 4))); else passed++;
        end
        in_valid = '0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL all_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready        = 1'b0;
        in_valid         = 4'b0100;
        in_data[23:16]   = 8'hA5;
        #1;
        checks++; if (in_ready !== 4'b0100) $display("FAIL bp_first_ready: got %b want 0100", in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA5)
            $display("FAIL bp_first_beat: got v=%b sel=%0d d=%h want v=1 sel=2 d=a5", out_valid, out_sel, out_data); else passed++;
        in_data[23:16] = 8'h5A;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++; if (in_ready !== 4'b0000) $display("FAIL bp_stall_ready: got %b want 0000", in_ready); else passed++;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
                $display("FAIL bp_hold: got v=%b d=%h want v=1 d=a5", out_valid, out_data); else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) $display("FAIL bp_release_ready: got %b want 0100", in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h5A)
            $display("FAIL bp_second_beat: got v=%b sel=%0d d=%h want v=1 sel=2 d=5a", out_valid, out_sel, out_data); else passed++;
        in_valid = '0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_wrap();
        in_valid       = 4'b1000;
        in_data[31:24] = 8'h33;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd3 || out_data !== 8'h33) $display("FAIL wrap_ch3: got sel=%0d d=%h want sel=3 d=33", out_sel, out_data); else passed++;
        in_valid      = 4'b1001;
        in_data[7:0]  = 8'h0C;
        #1;
        checks++; if (in_ready !== 4'b0001) $display("FAIL wrap_ready: got %b want 0001", in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd0 || out_data !== 8'h0C) $display("FAIL wrap_ch0: got sel=%0d d=%h want sel=0 d=0c", out_sel, out_data); else passed++;
        in_valid = 4'b1000;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd3 || out_valid !== 1'b1) $display("FAIL wrap_ch3_again: got sel=%0d v=%b want sel=3 v=1", out_sel, out_valid); else passed++;
        in_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        in_valid       = 4'b0010;
        in_data[15:8]  = 8'h77;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd1 || out_valid !== 1'b1) $display("FAIL arst_pre: got sel=%0d v=%b want sel=1 v=1", out_sel, out_valid); else passed++;
        in_data  = 32'h43322110;
        in_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0)
            $display("FAIL arst_clear: got v=%b d=%h sel=%0d want v=0 d=00 sel=0", out_valid, out_data, out_sel); else passed++;
        checks++; if (in_ready !== 4'b0000) $display("FAIL arst_ready: got %b want 0000", in_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) $display("FAIL arst_ptr_ready: got %b want 0001", in_ready); else passed++;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd0 || out_data !== 8'h10) $display("FAIL arst_first_grant: got sel=%0d d=%h want sel=0 d=10", out_sel, out_data); else passed++;
        in_valid = '0;
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending producers, pointer and output register tracked as plain integers.
    task automatic test_random(input int n);
        logic [3:0] pend;
        logic [7:0] d [4];
        int         m_ptr, m_sel, w, maxwait;
        logic       m_ov, load;
        logic [7:0] m_data;
        logic [3:0] exp_rdy;
        int         waits [4];
        do_reset();
        pend = '0; m_ptr = 0; m_sel = 0; m_ov = 1'b0; m_data = '0; maxwait = 0;
        for (int c = 0; c < 4; c++) begin d[c] = '0; waits[c] = 0; end
        for (int cyc = 0; cyc < n; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1'b1;
                    d[c]    = 8'($urandom);
                end
                in_data[c*8 +: 8] = d[c];
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            load = !m_ov || out_ready;
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            exp_rdy = (load && w >= 0) ? 4'(1 << w) : 4'b0000;
            checks++; if (in_ready !== exp_rdy) $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy); else passed++;
            @(posedge clk);
            #1;
            if (load) begin
                if (w >= 0) begin
                    for (int c = 0; c < 4; c++)
                        if (c != w && pend[c]) begin
                            waits[c]++;
                            if (waits[c] > maxwait) maxwait = waits[c];
                        end
                    waits[w] = 0;
                    m_ov = 1'b1; m_data = d[w]; m_sel = w; m_ptr = (w + 1) % 4;
                    pend[w] = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            checks++; if (out_valid !== m_ov || out_data !== m_data || out_sel !== 2'(m_sel))
                $display("FAIL rand_out cyc %0d: got v=%b d=%h sel=%0d want v=%b d=%h sel=%0d",
                         cyc, out_valid, out_data, out_sel, m_ov, m_data, m_sel); else passed++;
        end
        checks++; if (maxwait > 3) $display("FAIL rand_fairness: got max wait %0d want <= 3", maxwait); else passed++;
        in_valid  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef RR_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        do_reset();
        out_ready     = 1'b1;
        in_last       = 4'hF;
        in_valid      = 4'b0001;
        in_data[7:0]  = 8'hC0;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd0 || out_last !== 1'b1) $display("FAIL pkt_prime: got sel=%0d last=%b want sel=0 last=1", out_sel, out_last); else passed++;
        in_valid = 4'b0011;
        for (int b = 1; b <= 3; b++) begin
            in_data[15:8] = 8'(8'hB0 + b);
            in_last[1]    = (b == 3);
            #1;
            checks++; if (in_ready !== 4'b0010) $display("FAIL pkt_ready beat %0d: got %b want 0010", b, in_ready); else passed++;
            @(posedge clk);
            #1;
            checks++; if (out_sel !== 2'd1 || out_data !== 8'(8'hB0 + b) || out_last !== (b == 3))
                $display("FAIL pkt_beat %0d: got sel=%0d d=%h last=%b want sel=1 d=%h last=%b",
                         b, out_sel, out_data, out_last, 8'(8'hB0 + b), (b == 3)); else passed++;
        end
        in_valid = 4'b0001;
        @(posedge clk);
        #1;
        checks++; if (out_sel !== 2'd0 || out_data !== 8'hC0) $display("FAIL pkt_after: got sel=%0d d=%h want sel=0 d=c0", out_sel, out_data); else passed++;
        in_valid = '0;
        in_last  = 4'hF;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random(400);
`ifdef RR_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
